updown_counter_param: RTL and testbench
=======================================

// Module: updown_counter_param
// PURPOSE
//  Parametrised up/down counter; successor to the fixed 8-bit counter.
//  Adds configurable width, modulus and step size.
//  Adds synchronous clear and parallel load, a terminal-count flag and a registered wrap pulse.
//  Serves as the generic count/timebase block for later exercises (timers, dice, traffic light).
// PARAMETERS
//  WIDTH      8    counter width in bits (>=2)
//  MAX_COUNT  255  highest count value; count range 0..MAX_COUNT (MAX_COUNT <= 2**WIDTH-1)
//  STEP       1    increment/decrement per enabled cycle (1 <= STEP <= MAX_COUNT)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous reset, active-low
//  enable       in   1      count enable
//  direction    in   1      1 = count up, 0 = count down
//  clear        in   1      synchronous clear to 0
//  load         in   1      synchronous parallel load
//  load_value   in   WIDTH  value taken when load=1
//  counter_out  out  WIDTH  current count (registered)
//  tc           out  1      terminal count (combinational from counter_out/direction)
//  wrap         out  1      one-cycle registered pulse on wrap or saturation event
// BEHAVIOUR
//  - Reset: rst=0 forces counter_out=0 and wrap=0 immediately, without waiting for a clock edge.
//  - While rst=0, tc is still evaluated; with direction=0 it reads 1.
//  - Priority at each rising clk edge: clear > load > enable > hold.
//  - clear=1: counter_out<=0; wrap<=0.
//  - load=1: counter_out<=min(load_value, MAX_COUNT); wrap<=0.
//  - enable=1, direction=1: next = counter_out + STEP, computed WIDTH+1 bits wide.
//  - enable=1, direction=0: next = counter_out - STEP.
//  - Overflow/underflow are resolved as described under CONFIGURATION.
//  - enable=0 (and no clear/load): counter_out holds; wrap<=0.
//  - Latency: one clock from control input to counter_out; tc follows counter_out combinationally.
//  - tc=1 when direction=1 and counter_out > MAX_COUNT-STEP.
//  - tc=1 when direction=0 and counter_out < STEP.
//    => tc=1 means the next enabled count will wrap/saturate.
//  - wrap<=1 for exactly one cycle after an enabled cycle in which tc=1.
//  - wrap is never asserted by clear or load.
//  - direction may change on any cycle; it takes effect on the next enabled edge.
//  - Reset mid-count: the count is lost; counting resumes from 0 after rst returns to 1.
//  - No internal state exists beyond counter_out and wrap.
// CONFIGURATION
//  Macro COUNTER_SATURATE_EN.
//  - Undefined (default): modulo wrap over MAX_COUNT+1 values.
//    - Up overflow: counter_out <= counter_out + STEP - (MAX_COUNT+1).
//    - Down underflow: counter_out <= counter_out + (MAX_COUNT+1) - STEP.
//  - Defined: saturating count; wrap flags a saturation hit.
//    - Up overflow: counter_out <= MAX_COUNT.
//    - Down underflow: counter_out <= 0.
//    - wrap pulses on every enabled cycle that hits the limit, including when already pinned.
// TESTING
//  Bench defaults: WIDTH=8, MAX_COUNT=255, STEP=1, macro undefined, clk period 10 ns.
//  1 Reset: rst=0 mid-count -> counter_out=0 and wrap=0 before the next clk edge.
//    After release with enable=0 -> count holds at 0.
//  2 Up/down: enable=1, direction=1 for 5 clks -> counter_out=5.
//    Then direction=0 for 2 clks -> 3.
//    Then enable=0 for 3 clks -> holds 3.
//  3 Wrap: load 254, direction=1, enable=1.
//    -> Sequence 255 (tc=1), then 0 with wrap=1 for one cycle, then 1 with wrap=0.
//    Down from 0 -> 255 with wrap pulse.
//  4 Priority: clear=1, load=1, load_value=8'h40, enable=1 in the same cycle -> counter_out=0.
//    Then load=1 with enable=1 -> 8'h40.
//  5 Modulus/step: MAX_COUNT=9, STEP=3, load 8, up -> 1 (wrap=1).
//    Then down -> 8.
//    Then load_value=15 -> counter_out=9 (clamped).
//  6 COUNTER_SATURATE_EN defined: load 254, count up 3 clks -> 255,255,255.
//    wrap=1 on the 2nd and 3rd edges.
//    Down from 0 -> stays 0 with wrap=1.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clear, clamped load, terminal-count flag and wrap pulse.
// Define COUNTER_SATURATE_EN to saturate at 0/MAX_COUNT instead of wrapping modulo MAX_COUNT+1.
module updown_counter_param #(
   parameter int WIDTH     = 8,
   parameter int MAX_COUNT = 255,
   parameter int STEP      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             direction,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] counter_out,
   output logic             tc,
   output logic             wrap
);

   localparam int EW = WIDTH + 1;
   localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_COUNT);
   localparam logic [EW-1:0]    MAX_EXT  = EW'(MAX_COUNT);
   localparam logic [EW-1:0]    STEP_EXT = EW'(STEP);
`ifndef COUNTER_SATURATE_EN
   localparam logic [EW-1:0]    MOD_EXT  = EW'(MAX_COUNT + 1);
`endif

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic [EW-1:0]    cnt_ext;

   // Arithmetic is one bit wider so the up-sum cannot alias before the overflow test.
   assign cnt_ext = {1'b0, count_q};
   assign tc      = direction ? (cnt_ext > (MAX_EXT - STEP_EXT)) : (cnt_ext < STEP_EXT);

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = (load_value > MAX_W) ? MAX_W : load_value;
      end else if (enable) begin
         wrap_d = tc;
         if (direction) begin
            if (tc) begin
`ifdef COUNTER_SATURATE_EN
               count_d = MAX_W;
`else
               count_d = WIDTH'(cnt_ext + STEP_EXT - MOD_EXT);
`endif
            end else begin
               count_d = WIDTH'(cnt_ext + STEP_EXT);
            end
         end else begin
            if (tc) begin
`ifdef COUNTER_SATURATE_EN
               count_d = '0;
`else
               count_d = WIDTH'(cnt_ext + MOD_EXT - STEP_EXT);
`endif
            end else begin
               count_d = WIDTH'(cnt_ext - STEP_EXT);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign counter_out = count_q;
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: a default instance and a MAX_COUNT=9/STEP=3 instance.
// Expectations follow COUNTER_SATURATE_EN when the bench is built with it defined.
module tb_updown_counter_param;

`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk;
   logic       rst;

   logic       a_en, a_dir, a_clr, a_ld;
   logic [7:0] a_lv;
   logic [7:0] a_cnt;
   logic       a_tc, a_wrap;

   logic       b_en, b_dir, b_clr, b_ld;
   logic [7:0] b_lv;
   logic [7:0] b_cnt;
   logic       b_tc, b_wrap;

   int n_checks = 0;
   int n_pass   = 0;

   updown_counter_param #(.WIDTH(8), .MAX_COUNT(255), .STEP(1)) dut_a (
      .clk(clk), .rst(rst), .enable(a_en), .direction(a_dir), .clear(a_clr),
      .load(a_ld), .load_value(a_lv), .counter_out(a_cnt), .tc(a_tc), .wrap(a_wrap)
   );

   updown_counter_param #(.WIDTH(8), .MAX_COUNT(9), .STEP(3)) dut_b (
      .clk(clk), .rst(rst), .enable(b_en), .direction(b_dir), .clear(b_clr),
      .load(b_ld), .load_value(b_lv), .counter_out(b_cnt), .tc(b_tc), .wrap(b_wrap)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected summary before 100000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst = 1'b0;
      a_en = 0; a_dir = 0; a_clr = 0; a_ld = 0; a_lv = 8'd0;
      b_en = 0; b_dir = 0; b_clr = 0; b_ld = 0; b_lv = 8'd0;

      // reset state
      #2;
      chk("rst_cnt", a_cnt, 0);
      chk("rst_wrap", a_wrap, 0);
      chk("rst_tc_down", a_tc, 1);
      #10 rst = 1'b1;
      step();
      chk("hold_after_rst", a_cnt, 0);

      // up 5, down 2, hold 3
      a_en = 1; a_dir = 1;
      steps(5);
      chk("up5", a_cnt, 5);
      chk("up5_tc", a_tc, 0);
      a_dir = 0;
      steps(2);
      chk("down2", a_cnt, 3);
      a_en = 0;
      steps(3);
      chk("hold3", a_cnt, 3);

      // asynchronous reset mid-count
      a_en = 1; a_dir = 1;
      step();
      chk("pre_rst", a_cnt, 4);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_cnt", a_cnt, 0);
      chk("async_rst_wrap", a_wrap, 0);
      a_en = 0;
      #1 rst = 1'b1;
      step();
      chk("post_rst_hold", a_cnt, 0);

      // wrap / saturate upward
      a_ld = 1; a_lv = 8'd254;
      step();
      chk("load254", a_cnt, 254);
      chk("load254_tc", a_tc, 0);
      a_ld = 0; a_en = 1; a_dir = 1;
      step();
      chk("up_255", a_cnt, 255);
      chk("up_255_tc", a_tc, 1);
      chk("up_255_wrap", a_wrap, 0);
      step();
      chk("up_over_cnt", a_cnt, SAT ? 255 : 0);
      chk("up_over_wrap", a_wrap, 1);
      step();
      chk("up_next_cnt", a_cnt, SAT ? 255 : 1);
      chk("up_next_wrap", a_wrap, SAT ? 1 : 0);

      // wrap / saturate downward from 0
      a_ld = 1; a_lv = 8'd0;
      step();
      chk("load0_cnt", a_cnt, 0);
      chk("load0_wrap", a_wrap, 0);
      a_ld = 0; a_dir = 0;
      #1;
      chk("down0_tc", a_tc, 1);
      step();
      chk("down_under_cnt", a_cnt, SAT ? 0 : 255);
      chk("down_under_wrap", a_wrap, 1);
      step();
      chk("down_next_cnt", a_cnt, SAT ? 0 : 254);
      chk("down_next_wrap", a_wrap, SAT ? 1 : 0);

      // priority: clear > load > enable
      a_clr = 1; a_ld = 1; a_lv = 8'h40; a_dir = 1;
      step();
      chk("clr_prio", a_cnt, 0);
      chk("clr_wrap", a_wrap, 0);
      a_clr = 0;
      step();
      chk("load_prio", a_cnt, 8'h40);
      a_lv = 8'd255;
      step();
      chk("load255", a_cnt, 255);
      a_lv = 8'd5;
      step();
      chk("load_at_tc_cnt", a_cnt, 5);
      chk("load_at_tc_wrap", a_wrap, 0);
      a_ld = 0; a_en = 0;

      // modulus 10, step 3
      b_ld = 1; b_lv = 8'd8;
      step();
      chk("b_load8", b_cnt, 8);
      b_ld = 0; b_en = 1; b_dir = 1;
      #1;
      chk("b_tc_up", b_tc, 1);
      step();
      chk("b_up_cnt", b_cnt, SAT ? 9 : 1);
      chk("b_up_wrap", b_wrap, 1);
      b_dir = 0;
      step();
      chk("b_down_cnt", b_cnt, SAT ? 6 : 8);
      chk("b_down_wrap", b_wrap, SAT ? 0 : 1);
      b_en = 0; b_ld = 1; b_lv = 8'd15;
      step();
      chk("b_clamp", b_cnt, 9);
      chk("b_clamp_wrap", b_wrap, 0);
      b_ld = 0; b_en = 1; b_dir = 0;
      step();
      chk("b_mid_down", b_cnt, 6);
      chk("b_mid_wrap", b_wrap, 0);
      chk("b_mid_tc", b_tc, 0);
      b_en = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
